ad9361_axis_burst_framer: RTL and testbench



---
 rtl/ad9361_axis_burst_framer.sv | 143 ++++++++++++++
 tb/tb_ad9361_axis_burst_framer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_axis_burst_framer.sv
// ad9361_axis_burst_framer: frames the continuous AD9361 I/Q stream into all-or-nothing DMA bursts
// with a timestamped header beat; whole bursts are dropped and counted when buffer space runs out.
module ad9361_axis_burst_framer #(
    parameter int          BURST_LENGTH = 512,
    parameter int          FIFO_DEPTH   = 1024,
    parameter logic [15:0] HEADER_MAGIC = 16'hAD91
) (
    input  logic         axis_clk,
    input  logic         axis_resetn,
    input  logic         enable,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic [127:0] s_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tlast,
    output logic [31:0]  overflow_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_LENGTH);
    localparam int MD = (FIFO_DEPTH / BURST_LENGTH > 1) ? FIFO_DEPTH / BURST_LENGTH : 2;
    localparam int MW = $clog2(MD);
    localparam logic [AW+1:0] FD_W = (AW+2)'(FIFO_DEPTH);
    localparam logic [AW+1:0] BL_W = (AW+2)'(BURST_LENGTH);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t        state;
    logic [63:0]   ts_cnt, slot_ts;
    logic [BW-1:0] in_cnt, out_cnt;
    logic          slot_acc, drop_flag, first_flag;
    logic [AW:0]   s_wr, s_rd, occ;
    logic [MW:0]   m_wr, m_rd;
    logic [127:0]  s_mem [FIFO_DEPTH];
    logic [65:0]   m_mem [MD];
    logic          meta_push;
    logic [65:0]   meta_wdata, meta_head;
    logic [31:0]   seq_num;
    logic          in_hs, first_beat, last_beat, room, acc, meta_empty;

    assign s_axis_tready = axis_resetn;
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign occ           = s_wr - s_rd;
    assign room          = ({1'b0, occ} + BL_W) <= FD_W;
    assign first_beat    = in_cnt == '0;
    assign last_beat     = &in_cnt;
    assign acc           = first_beat ? (enable & room) : slot_acc;
    assign meta_empty    = m_wr == m_rd;
    assign meta_head     = m_mem[m_rd[MW-1:0]];

    always_ff @(posedge axis_clk) begin
        if (in_hs && acc)
            s_mem[s_wr[AW-1:0]] <= s_axis_tdata;
        if (meta_push)
            m_mem[m_wr[MW-1:0]] <= meta_wdata;
    end

    // Input side never stalls; the admission decision on a slot's first beat holds for the whole slot.
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            ts_cnt         <= '0;
            in_cnt         <= '0;
            slot_acc       <= 1'b0;
            slot_ts        <= '0;
            drop_flag      <= 1'b0;
            first_flag     <= 1'b1;
            s_wr           <= '0;
            m_wr           <= '0;
            overflow_count <= '0;
            meta_push      <= 1'b0;
            meta_wdata     <= '0;
        end else begin
            meta_push <= in_hs & acc & last_beat;
            if (meta_push)
                m_wr <= m_wr + (MW+1)'(1);
            if (in_hs) begin
                ts_cnt <= ts_cnt + 64'd1;
                in_cnt <= in_cnt + BW'(1);
                if (first_beat) begin
                    slot_acc <= acc;
                    slot_ts  <= ts_cnt;
                    if (enable && !room) begin
                        overflow_count <= (&overflow_count) ? overflow_count : overflow_count + 32'd1;
                        drop_flag      <= 1'b1;
                    end
                end
                if (acc)
                    s_wr <= s_wr + (AW+1)'(1);
                if (acc && last_beat) begin
                    meta_wdata <= {slot_ts, drop_flag, first_flag};
                    drop_flag  <= 1'b0;
                    first_flag <= 1'b0;
                end
            end
        end
    end

    // Output register reloads from the fall-through sample FIFO on each handshake, so no bubbles.
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            out_cnt       <= '0;
            s_rd          <= '0;
            m_rd          <= '0;
            seq_num       <= '0;
        end else begin
            case (state)
                IDLE: if (!meta_empty) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= 1'b0;
                    m_axis_tdata  <= {HEADER_MAGIC, 14'd0, meta_head[0], meta_head[1], seq_num, meta_head[65:2]};
                    state         <= HEADER;
                end
                HEADER: if (m_axis_tready) begin
                    m_axis_tdata <= s_mem[s_rd[AW-1:0]];
                    m_axis_tlast <= 1'b0;
                    s_rd         <= s_rd + (AW+1)'(1);
                    out_cnt      <= '0;
                    state        <= DATA;
                end
                DATA: if (m_axis_tready) begin
                    if (m_axis_tlast) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        m_rd          <= m_rd + (MW+1)'(1);
                        seq_num       <= seq_num + 32'd1;
                        state         <= IDLE;
                    end else begin
                        m_axis_tdata <= s_mem[s_rd[AW-1:0]];
                        m_axis_tlast <= out_cnt == BW'(BURST_LENGTH - 2);
                        s_rd         <= s_rd + (AW+1)'(1);
                        out_cnt      <= out_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ad9361_axis_burst_framer.sv
// tb_ad9361_axis_burst_framer: directed checks of framing, overflow, backpressure, enable, reset and
// counter saturation with BURST_LENGTH=4, FIFO_DEPTH=8.
module tb_ad9361_axis_burst_framer;
    logic         axis_clk = 1'b0;
    logic         axis_resetn = 1'b0;
    logic         enable = 1'b0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [127:0] s_axis_tdata = '0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tlast;
    logic [31:0]  overflow_count;

    int passed = 0, failed = 0, total = 0, cyc = 0;

    typedef struct {logic [127:0] d; logic l; int c;} beat_t;
    beat_t q[$];

    ad9361_axis_burst_framer #(.BURST_LENGTH(4), .FIFO_DEPTH(8), .HEADER_MAGIC(16'hAD91)) dut (
        .axis_clk(axis_clk), .axis_resetn(axis_resetn), .enable(enable),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .overflow_count(overflow_count)
    );

    always #5 axis_clk = ~axis_clk;
    always @(posedge axis_clk) cyc <= cyc + 1;
    // Output handshakes are captured mid-cycle; inputs only change just after a rising edge.
    always @(negedge axis_clk)
        if (axis_resetn && m_axis_tvalid && m_axis_tready)
            q.push_back('{m_axis_tdata, m_axis_tlast, cyc});

    function automatic logic [127:0] hdr(input logic first, input logic drop, input logic [31:0] seq, input logic [63:0] ts);
        return {16'hAD91, 14'd0, first, drop, seq, ts};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [127:0] d, input logic l);
        if (i < q.size()) begin
            chk({tag, ".data"}, q[i].d, d);
            chk1({tag, ".last"}, q[i].l, l);
        end else
            chkn({tag, ".missing"}, q.size(), i + 1);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge axis_clk);
            #1;
        end
    endtask

    task automatic beat(input logic [127:0] d);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        tick(1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset;
        axis_resetn = 1'b0;
        tick(2);
        axis_resetn = 1'b1;
        q.delete();
    endtask

    initial begin
        logic [127:0] pd;
        logic         stall;
        #2;
        chk1("rst_tvalid", m_axis_tvalid, 1'b0);
        chk1("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_ovf", 128'(overflow_count), '0);
        chk1("rst_sready", s_axis_tready, 1'b0);
        tick(2);
        axis_resetn = 1'b1;
        #1;
        chk1("sready_up", s_axis_tready, 1'b1);

        // Basic framing: two bursts from 8 continuous beats.
        enable = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            beat(128'(i));
            if (i == 4) chk1("hdr_lat_0", m_axis_tvalid, 1'b0);
            if (i == 5) chk1("hdr_lat_1", m_axis_tvalid, 1'b0);
            if (i == 6) begin
                chk1("hdr_lat_2", m_axis_tvalid, 1'b1);
                chk("hdr_lat_data", m_axis_tdata, hdr(1'b1, 1'b0, 32'd0, 64'd0));
            end
        end
        tick(12);
        chkn("basic_count", q.size(), 10);
        chk_beat("basic_h0", 0, hdr(1'b1, 1'b0, 32'd0, 64'd0), 1'b0);
        for (int i = 1; i <= 4; i++)
            chk_beat("basic_s0", i, 128'(i), i == 4);
        chk_beat("basic_h1", 5, hdr(1'b0, 1'b0, 32'd1, 64'd4), 1'b0);
        for (int i = 6; i <= 9; i++)
            chk_beat("basic_s1", i, 128'(i - 1), i == 9);
        if (q.size() == 10) begin
            chkn("no_bubble", q[4].c - q[0].c, 4);
            chkn("idle_gap", q[5].c - q[4].c, 2);
        end

        // Overflow: output stalled, slots 2 and 3 must be dropped.
        do_reset;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            beat(128'(100 + i));
            if (i == 7) chk("ovf_before", 128'(overflow_count), 128'(0));
            if (i == 8) chk("ovf_update", 128'(overflow_count), 128'(1));
        end
        chk("ovf_count", 128'(overflow_count), 128'(2));
        chk1("ovf_stall_valid", m_axis_tvalid, 1'b1);
        chk("ovf_stall_hdr", m_axis_tdata, hdr(1'b1, 1'b0, 32'd0, 64'd0));
        m_axis_tready = 1'b1;
        tick(16);
        chkn("ovf_pkts", q.size(), 10);
        chk_beat("ovf_h0", 0, hdr(1'b1, 1'b0, 32'd0, 64'd0), 1'b0);
        chk_beat("ovf_s0_last", 4, 128'(103), 1'b1);
        chk_beat("ovf_h1", 5, hdr(1'b0, 1'b0, 32'd1, 64'd4), 1'b0);
        chk_beat("ovf_s1_last", 9, 128'(107), 1'b1);
        q.delete();
        for (int i = 0; i < 4; i++)
            beat(128'(200 + i));
        tick(10);
        chkn("ovf_next_count", q.size(), 5);
        chk_beat("ovf_h2", 0, hdr(1'b0, 1'b1, 32'd2, 64'd16), 1'b0);
        chk_beat("ovf_s2_first", 1, 128'(200), 1'b0);
        chk_beat("ovf_s2_last", 4, 128'(203), 1'b1);

        // Backpressure: ready toggles every cycle once the header is up.
        do_reset;
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++)
            beat(128'(32'hA0 + i));
        tick(2);
        chk1("bp_hdr_valid", m_axis_tvalid, 1'b1);
        for (int k = 0; k < 14; k++) begin
            m_axis_tready = (k % 2 == 0);
            stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            tick(1);
            if (stall) begin
                chk("bp_hold_data", m_axis_tdata, pd);
                chk1("bp_hold_valid", m_axis_tvalid, 1'b1);
            end
        end
        chkn("bp_count", q.size(), 5);
        chk_beat("bp_h", 0, hdr(1'b1, 1'b0, 32'd0, 64'd0), 1'b0);
        for (int i = 1; i <= 4; i++)
            chk_beat("bp_s", i, 128'(32'hA0 + i), i == 4);

        // Enable dropped on the second beat of a slot.
        do_reset;
        m_axis_tready = 1'b1;
        enable = 1'b1;
        beat(128'(1));
        enable = 1'b0;
        for (int i = 2; i <= 8; i++)
            beat(128'(i));
        enable = 1'b1;
        for (int i = 9; i <= 12; i++)
            beat(128'(i));
        tick(12);
        chk("en_ovf", 128'(overflow_count), 128'(0));
        chkn("en_count", q.size(), 10);
        chk_beat("en_h0", 0, hdr(1'b1, 1'b0, 32'd0, 64'd0), 1'b0);
        chk_beat("en_s0_last", 4, 128'(4), 1'b1);
        chk_beat("en_h1", 5, hdr(1'b0, 1'b0, 32'd1, 64'd8), 1'b0);
        chk_beat("en_s1_first", 6, 128'(9), 1'b0);

        // Reset in the middle of a burst's data phase.
        do_reset;
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++)
            beat(128'(32'h50 + i));
        tick(2);
        m_axis_tready = 1'b1;
        tick(2);
        m_axis_tready = 1'b0;
        chk("mid_data2", m_axis_tdata, 128'(32'h52));
        #2 axis_resetn = 1'b0;
        #1;
        chk1("async_tvalid", m_axis_tvalid, 1'b0);
        chk("async_tdata", m_axis_tdata, '0);
        tick(2);
        axis_resetn = 1'b1;
        q.delete();
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 4; i++)
            beat(128'(32'h60 + i));
        tick(12);
        chkn("rst_count", q.size(), 5);
        chk_beat("rst_h", 0, hdr(1'b1, 1'b0, 32'd0, 64'd0), 1'b0);
        chk_beat("rst_s_first", 1, 128'(32'h61), 1'b0);

        // Saturation: preload the counter near its limit, then cause three drops.
        do_reset;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++)
            beat(128'(i));
        force dut.overflow_count = 32'hFFFFFFFE;
        beat(128'(8));
        release dut.overflow_count;
        for (int i = 9; i < 20; i++)
            beat(128'(i));
        chk("sat_ovf", 128'(overflow_count), 128'(32'hFFFFFFFF));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
